cordic_rot_seq: RTL and testbench

- Upstream sequencer and result buffer for the bit-serial CORDIC rotation core.
- Accepts a rotation request (x, y, angle) over a valid/ready handshake.
- Folds angles outside ±pi/2 into core range by pre-rotating the vector by pi, then converts the angle to the core's Q2.14 radian format.
- Pulses the core start, tracks core iteration progress until completion, then registers the rotated vector on a valid/ready output with timeout error reporting.

---
 rtl/cordic_rot_seq.sv | 228 ++++++++++++++++++++++
 tb/tb_cordic_rot_seq.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_rot_seq.sv
// cordic_rot_seq: request sequencer and result buffer in front of the
// bit-serial CORDIC rotation core. A request (x, y, angle) is folded into
// the core's +/-pi/2 convergence range and converted to Q2.14. The core is
// then launched and watched until it reports completion, and the rotated
// vector is held on a valid/ready output port. A core that never finishes
// produces an error result instead of a hang.
module cordic_rot_seq #(
  parameter int DONE_ITER = 13,
  parameter int SETTLE    = 2,
  parameter int TIMEOUT   = 300,
  parameter int W         = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_x,
  input  logic signed [W-1:0] in_y,
  input  logic signed [W-1:0] in_z,
  output logic                core_start,
  output logic signed [W-1:0] core_x0,
  output logic signed [W-1:0] core_y0,
  output logic signed [W-1:0] core_z0,
  input  logic [3:0]          core_iter,
  input  logic signed [W-1:0] core_x,
  input  logic signed [W-1:0] core_y,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_x,
  output logic signed [W-1:0] out_y,
  output logic                out_err,
  output logic                busy
);

  // Angle constants in the input format (Q3.13 radians)
  localparam logic signed [W-1:0] PI_HALF     = W'(12868);
  localparam logic signed [W-1:0] NEG_PI_HALF = W'(-12868);
  localparam logic signed [W-1:0] PI          = W'(25736);

  // Counter widths sized so the terminal values are representable
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT - 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);
  localparam logic [3:0]       ITER_DONE   = 4'(DONE_ITER);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    RUN,
    SETTLE_WAIT,
    OUT
  } state_t;

  state_t state, state_nxt;

  logic [TMO_W-1:0] tmo_cnt;
  logic [SET_W-1:0] settle_cnt;

  logic accept;
  logic run_done;
  logic run_tmo;
  logic settle_last;

  logic signed [W-1:0] fold_x;
  logic signed [W-1:0] fold_y;
  logic signed [W-1:0] fold_z;

  // Two's-complement negate that clamps the most negative value to the most
  // positive one instead of wrapping back onto itself.
  function automatic logic signed [W-1:0] neg_sat(input logic signed [W-1:0] v);
    logic signed [W-1:0] min_v;
    logic signed [W-1:0] max_v;
    min_v = {1'b1, {(W-1){1'b0}}};
    max_v = {1'b0, {(W-1){1'b1}}};
    if (v == min_v) begin
      return max_v;
    end
    return -v;
  endfunction

  // Q3.13 -> Q2.14 conversion; the folded angle is within +/-pi/2 so the
  // dropped top bit is always a copy of the sign.
  function automatic logic signed [W-1:0] to_q2_14(input logic signed [W-1:0] z);
    return {z[W-2:0], 1'b0};
  endfunction

  // Fold the request into core range: rotating the vector by pi (negating
  // it) and taking pi back off the angle leaves the final rotation unchanged.
  always_comb begin
    fold_x = in_x;
    fold_y = in_y;
    fold_z = in_z;
    if (in_z > PI_HALF) begin
      fold_z = in_z - PI;
      fold_x = neg_sat(in_x);
      fold_y = neg_sat(in_y);
    end else if (in_z < NEG_PI_HALF) begin
      fold_z = in_z + PI;
      fold_x = neg_sat(in_x);
      fold_y = neg_sat(in_y);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and per-state handshake/strobe outputs
  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    core_start  = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    accept      = 1'b0;
    run_done    = 1'b0;
    run_tmo     = 1'b0;
    settle_last = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        core_start = 1'b1;
        state_nxt  = RUN;
      end
      RUN: begin
        // tmo_cnt is zero only in the first RUN cycle, while the core is
        // still reloading its counter and core_iter may show a stale value.
        if ((tmo_cnt != '0) && (core_iter == ITER_DONE)) begin
          run_done  = 1'b1;
          state_nxt = SETTLE_WAIT;
        end else if (tmo_cnt == TMO_LAST) begin
          run_tmo   = 1'b1;
          state_nxt = OUT;
        end
      end
      SETTLE_WAIT: begin
        if (settle_cnt == SETTLE_LAST) begin
          settle_last = 1'b1;
          state_nxt   = OUT;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Core operands: captured on accept, held until the next accepted request
  always_ff @(posedge clk) begin
    if (rst) begin
      core_x0 <= '0;
      core_y0 <= '0;
      core_z0 <= '0;
    end else if (accept) begin
      core_x0 <= fold_x;
      core_y0 <= fold_y;
      core_z0 <= to_q2_14(fold_z);
    end
  end

  // Timeout counter: cleared at launch, counts every RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == LAUNCH) begin
      tmo_cnt <= '0;
    end else if (state == RUN) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Settle counter: lets core_x/core_y catch up after the final iteration
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= '0;
    end else if (run_done) begin
      settle_cnt <= '0;
    end else if (state == SETTLE_WAIT) begin
      settle_cnt <= settle_cnt + 1'b1;
    end
  end

  // Result buffer: loaded once per request, held through output backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      out_x   <= '0;
      out_y   <= '0;
      out_err <= 1'b0;
    end else if (run_tmo) begin
      out_x   <= '0;
      out_y   <= '0;
      out_err <= 1'b1;
    end else if (settle_last) begin
      out_x   <= core_x;
      out_y   <= core_y;
      out_err <= 1'b0;
    end
  end

  // The start strobe never lasts more than one cycle
  a_start_pulse: assert property (@(posedge clk) disable iff (rst)
    core_start |=> !core_start);

  // A stalled result stays put until it is taken
  a_out_hold: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_x) && $stable(out_y) && $stable(out_err)));

endmodule

// File: tb/tb_cordic_rot_seq.sv
// tb_cordic_rot_seq: randomized and directed requests against a stub
// rotation core; expected results come from real-valued rotation of the
// original request, expected core operands from the folding rules.
`timescale 1ns/1ps
module tb_cordic_rot_seq;
  localparam int  W         = 16;
  localparam int  DONE_ITER = 13;
  localparam int  SETTLE    = 2;
  localparam int  TIMEOUT   = 300;
  localparam real K         = 1.646760258;
  localparam int  TOL       = 8;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_x, in_y, in_z;
  logic                core_start;
  logic signed [W-1:0] core_x0, core_y0, core_z0;
  logic [3:0]          core_iter;
  logic signed [W-1:0] core_x, core_y;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_x, out_y;
  logic                out_err;
  logic                busy;

  cordic_rot_seq #(.DONE_ITER(DONE_ITER), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .core_start(core_start), .core_x0(core_x0), .core_y0(core_y0), .core_z0(core_z0),
    .core_iter(core_iter), .core_x(core_x), .core_y(core_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_err(out_err), .busy(busy)
  );

  typedef struct { int x; int y; bit err; } exp_t;
  typedef struct { int x0; int y0; int z0; } op_t;

  exp_t exp_q[$];
  op_t  op_q[$];

  int checks = 0;
  int fails  = 0;
  int cyc_cnt = 0;
  int starts = 0;
  int step = 3;
  bit hang = 0;
  bit rand_ready = 0;
  bit hold_ready = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time exhausted, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input bit ok, input int act, input int req);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int to_q(input real r);
    real c;
    c = r;
    if (c > 32767.0) c = 32767.0;
    if (c < -32768.0) c = -32768.0;
    return (c >= 0.0) ? $rtoi(c + 0.5) : $rtoi(c - 0.5);
  endfunction

  // Ideal CORDIC rotation including the uncompensated gain
  task automatic rotate(input int x, input int y, input real a, output int ox, output int oy);
    real c, s;
    c = $cos(a);
    s = $sin(a);
    ox = to_q(K * (x * c - y * s));
    oy = to_q(K * (x * s + y * c));
  endtask

  function automatic int neg_clamp(input int v);
    return (v == -32768) ? 32767 : -v;
  endfunction

  // Expected core operands from the folding rules
  function automatic op_t fold_model(input int x, input int y, input int z);
    op_t o;
    o.x0 = x;
    o.y0 = y;
    o.z0 = 2 * z;
    if (z > 12868) begin
      o.x0 = neg_clamp(x);
      o.y0 = neg_clamp(y);
      o.z0 = 2 * (z - 25736);
    end else if (z < -12868) begin
      o.x0 = neg_clamp(x);
      o.y0 = neg_clamp(y);
      o.z0 = 2 * (z + 25736);
    end
    return o;
  endfunction

  // Stub core: stale iteration count in the first run cycle, then one
  // iteration per `step` cycles; result appears SETTLE cycles after done.
  initial begin
    int cyc, done_at, it, sx, sy, sz, rx, ry;
    bit running;
    core_iter = 4'd13;
    core_x = '0;
    core_y = '0;
    running = 0;
    cyc = 0;
    done_at = -1;
    forever begin
      @(negedge clk);
      if (core_start) begin
        sx = core_x0;
        sy = core_y0;
        sz = core_z0;
        running = 1;
        cyc = 0;
        done_at = -1;
        core_x = 16'sh5A5A;
        core_y = 16'sh2A2B;
        if (hang) core_iter = 4'd5;
      end else if (running) begin
        cyc++;
        if (!hang && cyc >= 2) begin
          it = (cyc - 2) / step;
          if (it >= 13) it = 13;
          core_iter = 4'(it);
          if (it == 13 && done_at < 0) done_at = cyc;
          if (done_at >= 0 && cyc >= done_at + 2) begin
            rotate(sx, sy, sz / 16384.0, rx, ry);
            core_x = 16'(rx);
            core_y = 16'(ry);
          end
        end
      end
    end
  end

  // Output consumer
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = hold_ready ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Monitor: core operand checks at start, result checks at output handshake
  initial begin
    op_t  o;
    exp_t e;
    bit   held;
    int   hx, hy, he;
    held = 0;
    hx = 0;
    hy = 0;
    he = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 0;
      end else begin
        if (core_start) begin
          starts++;
          if (op_q.size() == 0) begin
            check("unexpected_core_start", 1'b0, 1, 0);
          end else begin
            o = op_q.pop_front();
            check("core_x0", core_x0 == o.x0, core_x0, o.x0);
            check("core_y0", core_y0 == o.y0, core_y0, o.y0);
            check("core_z0", core_z0 == o.z0, core_z0, o.z0);
          end
        end
        if (out_valid) begin
          if (held) begin
            check("hold_x", out_x == hx, out_x, hx);
            check("hold_y", out_y == hy, out_y, hy);
            check("hold_err", out_err == he, out_err, he);
          end
          if (out_ready) begin
            held = 0;
            if (exp_q.size() == 0) begin
              check("unexpected_output", 1'b0, 1, 0);
            end else begin
              e = exp_q.pop_front();
              check("out_err", out_err == e.err, out_err, e.err);
              if (e.err) begin
                check("err_out_x", out_x == 0, out_x, 0);
                check("err_out_y", out_y == 0, out_y, 0);
              end else begin
                check("out_x", iabs(out_x - e.x) <= TOL, out_x, e.x);
                check("out_y", iabs(out_y - e.y) <= TOL, out_y, e.y);
              end
            end
          end else begin
            held = 1;
            hx = out_x;
            hy = out_y;
            he = out_err;
          end
        end else begin
          held = 0;
        end
      end
    end
  end

  task automatic send(input int x, input int y, input int z);
    exp_t e;
    int rx, ry;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_x = 16'(x);
    in_y = 16'(y);
    in_z = 16'(z);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (in_ready) begin
        op_q.push_back(fold_model(x, y, z));
        if (hang) begin
          e = '{0, 0, 1'b1};
        end else begin
          rotate(x, y, z / 8192.0, rx, ry);
          e = '{rx, ry, 1'b0};
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_x = 16'($urandom);
        in_y = 16'($urandom);
        in_z = 16'($urandom);
        return;
      end
    end
    $display("FAIL send: in_ready stayed 0, expected 1 within 2000 cycles");
    fails++;
    $fatal(1, "send stalled");
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) return;
    end
    $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    fails++;
    $fatal(1, "drain stalled");
  endtask

  // Cycles from the core_start cycle to the first out_valid cycle
  task automatic measure(output int lat);
    int t0;
    t0 = -1;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (core_start) begin
        t0 = cyc_cnt;
        break;
      end
    end
    if (t0 < 0) return;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = cyc_cnt - t0;
        return;
      end
    end
  endtask

  initial begin
    int lat, s0, x, y, z;
    int bz[6];
    rst = 1'b1;
    in_valid = 1'b0;
    in_x = '0;
    in_y = '0;
    in_z = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready == 1'b1, in_ready, 1);
    check("rst_out_valid", out_valid == 1'b0, out_valid, 0);
    check("rst_core_start", core_start == 1'b0, core_start, 0);
    check("rst_busy", busy == 1'b0, busy, 0);
    check("rst_out_x", out_x == 0, out_x, 0);
    check("rst_out_y", out_y == 0, out_y, 0);
    check("rst_out_err", out_err == 1'b0, out_err, 0);
    check("rst_core_ops", {core_x0, core_y0, core_z0} == '0, core_z0, 0);
    rst = 1'b0;

    // Basic rotation with latency check
    step = 3;
    send(9949, 0, 0);
    measure(lat);
    check("basic_latency", lat == 13 * 3 + 3 + SETTLE, lat, 13 * 3 + 3 + SETTLE);
    wait_drain();

    // Positive fold, negative fold with saturating negate
    send(9949, 0, 16384);
    wait_drain();
    send(-32768, 100, -20480);
    wait_drain();

    // Fold boundaries
    bz = '{12868, 12869, -12868, -12869, 25736, -25736};
    foreach (bz[i]) begin
      step = 1 + i % 3;
      send(5000, -3000, bz[i]);
      wait_drain();
    end

    // Randomized requests with a randomly stalling consumer
    rand_ready = 1;
    for (int n = 0; n < 12; n++) begin
      step = $urandom_range(1, 6);
      x = $urandom_range(0, 19898) - 9949;
      y = $urandom_range(0, 19898) - 9949;
      z = $urandom_range(0, 51472) - 25736;
      send(x, y, z);
      wait_drain();
    end
    rand_ready = 0;

    // Output backpressure
    step = 2;
    hold_ready = 1;
    s0 = starts;
    send(-7000, 4000, 9000);
    for (int i = 0; i < 500 && !out_valid; i++) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready == 1'b0, in_ready, 0);
      check("bp_out_valid", out_valid == 1'b1, out_valid, 1);
    end
    check("bp_start_pulses", starts - s0 == 1, starts - s0, 1);
    hold_ready = 0;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_in_ready", in_ready == 1'b1, in_ready, 1);
    check("bp_release_out_valid", out_valid == 1'b0, out_valid, 0);
    wait_drain();

    // Timeout with a core stuck at iteration 5
    hang = 1;
    send(1000, 2000, 3000);
    measure(lat);
    check("timeout_latency", lat == TIMEOUT + 1, lat, TIMEOUT + 1);
    wait_drain();
    hang = 0;

    // Reset in the middle of a run, then a normal request
    step = 6;
    send(3000, 3000, -5000);
    for (int i = 0; i < 20 && !core_start; i++) @(negedge clk);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", in_ready == 1'b1, in_ready, 1);
    check("mid_rst_out_valid", out_valid == 1'b0, out_valid, 0);
    check("mid_rst_busy", busy == 1'b0, busy, 0);
    check("mid_rst_core_x0", core_x0 == 0, core_x0, 0);
    rst = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    step = 3;
    send(-4000, 6000, 20000);
    wait_drain();
    check("ops_consumed", op_q.size() == 0, op_q.size(), 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
